// File: rtl/pc_unit.sv
`default_nettype none
// ============================================================================
//  Module      : pc_unit
//  Description : Program-counter register and next-PC selection. Computes
//                sequential, branch, jump and register-jump targets, checks
//                each accepted target against the instruction-memory window,
//                and halts fetch (sticky pc_err) when a bad target is seen.
//
//  Ports
//    clk          in   1   clock, rising edge
//    reset        in   1   synchronous active-high reset
//    stall        in   1   hold PC this cycle
//    npc_op       in   2   00 seq, 01 branch, 10 jump, 11 register jump
//    branch_taken in   1   comparator result, used when npc_op = 01
//    imm          in  16   branch word offset
//    instr_index  in  26   jump index field
//    jr_target    in  32   register value for jr
//    PC           out 32   current PC (registered)
//    pc_plus4     out 32   PC + 4 (combinational, jal link value)
//    pc_err       out  1   sticky bad-target flag
//    instr_cnt    out 32   number of PC updates since reset
//
//  Revision    : 1.0  initial release
// ============================================================================
module pc_unit #(
    parameter logic [31:0] PC_RESET = 32'h0000_3000,
    parameter int          IM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic [1:0]  npc_op,
    input  logic        branch_taken,
    input  logic [15:0] imm,
    input  logic [25:0] instr_index,
    input  logic [31:0] jr_target,
    output logic [31:0] PC,
    output logic [31:0] pc_plus4,
    output logic        pc_err,
    output logic [31:0] instr_cnt
);

    localparam logic [0:0] c_st_run  = 1'b0;
    localparam logic [0:0] c_st_halt = 1'b1;

    localparam logic [1:0] c_op_seq = 2'b00;
    localparam logic [1:0] c_op_br  = 2'b01;
    localparam logic [1:0] c_op_j   = 2'b10;
    localparam logic [1:0] c_op_jr  = 2'b11;

    // Window bounds carried in 33 bits so the upper bound cannot wrap.
    localparam logic [32:0] c_win_lo = {1'b0, PC_RESET};
    localparam logic [32:0] c_win_hi = {1'b0, PC_RESET} + (33'(IM_WORDS) << 2);

    logic [0:0]  r_state;
    logic [31:0] r_pc;
    logic [31:0] r_cnt;
    logic        r_err;

    logic [0:0]  w_state_next;
    logic [31:0] w_pc_next;
    logic [31:0] w_cnt_next;
    logic        w_err_next;

    logic [31:0] w_pc_plus4;
    logic [31:0] w_br_off;
    logic [31:0] w_npc;
    logic        w_npc_valid;

    assign w_pc_plus4 = r_pc + 32'd4;
    assign w_br_off   = {{14{imm[15]}}, imm, 2'b00};

    // Next-PC candidate
    always_comb begin
        w_npc = w_pc_plus4;
        case (npc_op)
            c_op_seq: w_npc = w_pc_plus4;
            c_op_br:  w_npc = branch_taken ? (w_pc_plus4 + w_br_off) : w_pc_plus4;
            c_op_j:   w_npc = {w_pc_plus4[31:28], instr_index, 2'b00};
            c_op_jr:  w_npc = jr_target;
            default:  w_npc = w_pc_plus4;
        endcase
    end

    assign w_npc_valid = (w_npc[1:0] == 2'b00)
                      && ({1'b0, w_npc} >= c_win_lo)
                      && ({1'b0, w_npc} <  c_win_hi);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_st_run;
            r_pc    <= PC_RESET;
            r_cnt   <= 32'd0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
            r_cnt   <= w_cnt_next;
            r_err   <= w_err_next;
        end
    end

    // Next-state logic: HALT freezes everything; stall holds without checking.
    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        w_cnt_next   = r_cnt;
        w_err_next   = r_err;
        case (r_state)
            c_st_run: begin
                if (!stall) begin
                    if (w_npc_valid) begin
                        w_pc_next  = w_npc;
                        w_cnt_next = r_cnt + 32'd1;
                    end else begin
                        w_err_next   = 1'b1;
                        w_state_next = c_st_halt;
                    end
                end
            end
            c_st_halt: begin
                w_state_next = c_st_halt;
            end
            default: begin
                w_state_next = c_st_halt;
            end
        endcase
    end

    // Outputs
    always_comb begin
        PC        = r_pc;
        pc_plus4  = w_pc_plus4;
        pc_err    = r_err;
        instr_cnt = r_cnt;
    end

endmodule
`default_nettype wire

// File: tb/tb_pc_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pc_unit
//  Description : Self-checking bench for pc_unit: directed scenarios followed
//                by randomized traffic, compared against an arithmetic model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pc_unit;

    localparam logic [31:0] c_base  = 32'h0000_3000;
    localparam int          c_words = 1024;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic [1:0]  npc_op;
    logic        branch_taken;
    logic [15:0] imm;
    logic [25:0] instr_index;
    logic [31:0] jr_target;
    logic [31:0] PC;
    logic [31:0] pc_plus4;
    logic        pc_err;
    logic [31:0] instr_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    longint m_pc;
    longint m_cnt;
    bit     m_err;
    bit     m_halt;
    bit     m_known = 1'b0;

    pc_unit #(
        .PC_RESET (c_base),
        .IM_WORDS (c_words)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .npc_op       (npc_op),
        .branch_taken (branch_taken),
        .imm          (imm),
        .instr_index  (instr_index),
        .jr_target    (jr_target),
        .PC           (PC),
        .pc_plus4     (pc_plus4),
        .pc_err       (pc_err),
        .instr_cnt    (instr_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    // Model of one rising edge, straight from the behavioural rules.
    task automatic model_edge();
        longint mask, p4, npc, off;
        mask = 64'hFFFF_FFFF;
        if (reset) begin
            m_pc = c_base; m_cnt = 0; m_err = 0; m_halt = 0; m_known = 1;
            return;
        end
        if (!m_known || m_halt || stall) return;
        p4 = (m_pc + 4) & mask;
        case (npc_op)
            2'b00: npc = p4;
            2'b01: begin
                off = longint'($signed(imm)) * 4;
                npc = branch_taken ? ((p4 + off) & mask) : p4;
            end
            2'b10: npc = (p4 & 64'hF000_0000) | (longint'(instr_index) * 4);
            default: npc = longint'(jr_target);
        endcase
        if ((npc % 4) == 0 && npc >= c_base && npc < longint'(c_base) + 4 * c_words) begin
            m_pc  = npc;
            m_cnt = (m_cnt + 1) & mask;
        end else begin
            m_err  = 1;
            m_halt = 1;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        if (m_known) begin
            check("pc",       PC,                        32'(m_pc));
            check("pc_plus4", pc_plus4,                  32'((m_pc + 4) & 64'hFFFF_FFFF));
            check("pc_err",   {31'd0, pc_err},           {31'd0, m_err});
            check("cnt",      instr_cnt,                 32'(m_cnt));
        end
    endtask

    task automatic apply(input logic rst, input logic stl, input logic [1:0] op,
                         input logic bt, input logic [15:0] im,
                         input logic [25:0] idx, input logic [31:0] jr);
        reset = rst; stall = stl; npc_op = op; branch_taken = bt;
        imm = im; instr_index = idx; jr_target = jr;
        step();
    endtask

    initial begin
        int r;
        apply(1, 0, 2'b00, 0, 16'h0, 26'h0, 32'h0);
        check("rst_pc",  PC, 32'h3000);
        check("rst_p4",  pc_plus4, 32'h3004);
        check("rst_cnt", instr_cnt, 32'd0);

        // Sequential fetch
        repeat (3) apply(0, 0, 2'b00, 0, 16'h0, 26'h0, 32'h0);
        check("seq_pc",  PC, 32'h300C);
        check("seq_cnt", instr_cnt, 32'd3);
        apply(0, 0, 2'b00, 0, 16'h0, 26'h0, 32'h0);
        // Backward taken branch from 3010
        apply(0, 0, 2'b01, 1, 16'hFFFC, 26'h0, 32'h0);
        check("br_taken", PC, 32'h3004);
        repeat (3) apply(0, 0, 2'b00, 0, 16'h0, 26'h0, 32'h0);
        apply(0, 0, 2'b01, 0, 16'hFFFC, 26'h0, 32'h0);
        check("br_not", PC, 32'h3014);

        // Jump, then misaligned jr halts
        apply(1, 0, 2'b00, 0, 16'h0, 26'h0, 32'h0);
        apply(0, 0, 2'b10, 0, 16'h0, 26'h000_0C10, 32'h0);
        check("jump", PC, 32'h3040);
        apply(0, 0, 2'b11, 0, 16'h0, 26'h0, 32'h0000_3002);
        check("jr_bad_pc",  PC, 32'h3040);
        check("jr_bad_err", {31'd0, pc_err}, 32'd1);
        repeat (5) apply(0, 0, 2'b00, 0, 16'h0, 26'h0, 32'h0);
        check("halt_pc",  PC, 32'h3040);
        check("halt_cnt", instr_cnt, 32'd1);

        // Stall suppresses the check on a bad target
        apply(1, 0, 2'b00, 0, 16'h0, 26'h0, 32'h0);
        repeat (4) apply(0, 1, 2'b11, 0, 16'h0, 26'h0, 32'h0);
        check("stall_pc",  PC, 32'h3000);
        check("stall_err", {31'd0, pc_err}, 32'd0);
        apply(0, 0, 2'b00, 0, 16'h0, 26'h0, 32'h0);
        check("unstall_pc", PC, 32'h3004);

        // Last word of the window, then fall off the end
        apply(0, 0, 2'b11, 0, 16'h0, 26'h0, 32'h0000_3FFC);
        check("last_word", PC, 32'h3FFC);
        apply(0, 0, 2'b00, 0, 16'h0, 26'h0, 32'h0);
        check("end_pc",  PC, 32'h3FFC);
        check("end_err", {31'd0, pc_err}, 32'd1);
        apply(1, 0, 2'b00, 0, 16'h0, 26'h0, 32'h0);
        check("rerst_pc",  PC, 32'h3000);
        check("rerst_err", {31'd0, pc_err}, 32'd0);
        check("rerst_cnt", instr_cnt, 32'd0);

        // Just below the window
        apply(0, 0, 2'b11, 0, 16'h0, 26'h0, 32'h0000_2FFC);
        check("below_err", {31'd0, pc_err}, 32'd1);
        apply(1, 0, 2'b00, 0, 16'h0, 26'h0, 32'h0);

        // Randomized traffic, mostly in-window targets
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] tgt;
            r   = $urandom_range(0, 99);
            tgt = c_base + 32'($urandom_range(0, c_words - 1)) * 4;
            if ($urandom_range(0, 19) == 0) tgt = $urandom;
            else if ($urandom_range(0, 19) == 0) tgt = tgt + 32'($urandom_range(1, 3));
            apply(r < 2,
                  $urandom_range(0, 4) == 0,
                  2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)),
                  16'($signed($urandom_range(0, 64)) - 32),
                  ($urandom_range(0, 9) == 0) ? 26'($urandom) : tgt[27:2],
                  tgt);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
